// File: rtl/cordic_rot_iter.sv
// cordic_rot_iter: word-serial CORDIC engine in rotation mode.
// Rotates (Xin, Yin) by Zin over eight micro-rotations, one per clock.
// The iteration index goes out on Count3 and the matching atan(2^-i) comes
// back combinationally on Thetai in the same cycle.
// Optional build macro GAIN_COMP_EN adds a one-cycle COMP state that scales
// the result by about 0.60742 to cancel the CORDIC gain.
module cordic_rot_iter #(
  parameter int W     = 12,
  parameter int NITER = 8
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                Start,
  output logic                Ready,
  input  logic signed [W-1:0] Xin,
  input  logic signed [W-1:0] Yin,
  input  logic signed [7:0]   Zin,
  output logic [2:0]          Count3,
  input  logic [7:0]          Thetai,
  output logic signed [W+1:0] Xout,
  output logic signed [W+1:0] Yout,
  output logic signed [7:0]   Zres,
  output logic                Busy,
  output logic                Done
);

  localparam int DW = W + 2;
  localparam logic [2:0] LAST_IDX = 3'(NITER - 1);

`ifdef GAIN_COMP_EN
  typedef enum logic [1:0] {IDLE, RUN, COMP} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  state_t state, state_d;

  logic signed [DW-1:0] x_q, y_q;
  logic signed [DW-1:0] x_sh, y_sh;
  logic signed [DW-1:0] x_it, y_it;
  logic signed [7:0]    z_q, z_it;

`ifdef GAIN_COMP_EN
  // Multiply by 2^-1 + 2^-3 - 2^-6 - 2^-9 using truncating arithmetic shifts.
  function automatic logic signed [DW-1:0] gain_comp(input logic signed [DW-1:0] v);
    return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9);
  endfunction
`endif

  // One micro-rotation: direction follows the sign of the residual angle.
  always_comb begin
    x_sh = x_q >>> Count3;
    y_sh = y_q >>> Count3;
    if (z_q[7]) begin
      x_it = x_q + y_sh;
      y_it = y_q - x_sh;
      z_it = z_q + Thetai;
    end else begin
      x_it = x_q - y_sh;
      y_it = y_q + x_sh;
      z_it = z_q - Thetai;
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d = state;
    Ready   = 1'b0;
    Busy    = 1'b0;
    case (state)
      IDLE: begin
        Ready = 1'b1;
        if (Start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        Busy = 1'b1;
        if (Count3 == LAST_IDX) begin
`ifdef GAIN_COMP_EN
          state_d = COMP;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef GAIN_COMP_EN
      COMP: begin
        Busy    = 1'b1;
        state_d = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: operand load, iteration, and held result registers with Done pulse.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      Count3 <= '0;
      Xout   <= '0;
      Yout   <= '0;
      Zres   <= '0;
      Done   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            x_q    <= {{2{Xin[W-1]}}, Xin};
            y_q    <= {{2{Yin[W-1]}}, Yin};
            z_q    <= Zin;
            Count3 <= '0;
          end
        end
        RUN: begin
          x_q <= x_it;
          y_q <= y_it;
          z_q <= z_it;
          if (Count3 == LAST_IDX) begin
            Count3 <= '0;
`ifndef GAIN_COMP_EN
            Xout   <= x_it;
            Yout   <= y_it;
            Zres   <= z_it;
            Done   <= 1'b1;
`endif
          end else begin
            Count3 <= Count3 + 3'd1;
          end
        end
`ifdef GAIN_COMP_EN
        COMP: begin
          Xout <= gain_comp(x_q);
          Yout <= gain_comp(y_q);
          Zres <= z_q;
          Done <= 1'b1;
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule
